vpu_stream_sink: RTL and testbench

Receiving end of the VPU tensor stream. Each cycle the upstream VPU stimulus source may present one packet (valid flag, 16-bit channel address, 16-bit Tmax, 1024-bit tensor) and cannot be back-pressured. This block captures valid packets into an internal FIFO and replays each packet downstream as a header beat plus narrow tensor beats on a valid/ready interface. FIFO overflow drops the packet and counts the loss.

---
 rtl/vpu_stream_sink_if.sv | 27 ++
 rtl/vpu_stream_sink.sv | 199 +++++++++++++++++++
 tb/tb_vpu_stream_sink.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_stream_sink_if.sv
// vpu_stream_sink_if: downstream beat stream.
// Header beat then tensor beats on valid/ready.
interface vpu_stream_sink_if #(
  parameter int BEAT_WIDTH = 64
);
  logic                  out_valid;
  logic                  out_ready;
  logic [BEAT_WIDTH-1:0] out_data;
  logic                  out_first;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_first,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/vpu_stream_sink.sv
// vpu_stream_sink: captures unthrottled tensor packets
// into a FIFO and replays them as header + body beats.
module vpu_stream_sink #(
  parameter int TENSOR_WIDTH   = 1024,
  parameter int BEAT_WIDTH     = 64,
  parameter int FIFO_ADDR_SIZE = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [15:0]             in_chnaddr,
  input  logic [15:0]             in_tmax,
  input  logic [TENSOR_WIDTH-1:0] in_tensors,
  vpu_stream_sink_if.master       m_out,
  output logic [FIFO_ADDR_SIZE:0] fifo_count,
  output logic [15:0]             drop_count,
  output logic                    overflow
);
  localparam int NBEAT = TENSOR_WIDTH / BEAT_WIDTH;
  localparam int IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int DEPTH = 1 << FIFO_ADDR_SIZE;
  localparam int AW    = FIFO_ADDR_SIZE;
  localparam logic [AW:0]   LP_FULL = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LP_LAST = IW'(NBEAT-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_BODY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TENSOR_WIDTH-1:0] r_mem_t [DEPTH];
  logic [31:0]             r_mem_h [DEPTH];

  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [AW-1:0]         w_rd_nx;
  logic [AW:0]           r_count;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [15:0]           r_drop;
  logic                  r_ovf;
  logic                  r_valid;
  logic                  r_first;
  logic                  r_last;
  logic [BEAT_WIDTH-1:0] r_data;
  logic                  w_valid_nxt;
  logic                  w_first_nxt;
  logic                  w_last_nxt;
  logic [BEAT_WIDTH-1:0] w_data_nxt;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_full;
  logic [31:0]           w_next_h;

  function automatic logic [BEAT_WIDTH-1:0] f_hdr(
    input logic [31:0] h
  );
    logic [BEAT_WIDTH-1:0] v;
    v       = '0;
    v[31:0] = h;
    return v;
  endfunction

  function automatic logic [BEAT_WIDTH-1:0] f_beat(
    input logic [TENSOR_WIDTH-1:0] t,
    input logic [IW-1:0]           i
  );
    return t[BEAT_WIDTH*int'(i) +: BEAT_WIDTH];
  endfunction

  assign w_xfer  = r_valid & m_out.out_ready;
  assign w_pop   = w_xfer & (r_state == S_BODY)
                 & (r_idx == LP_LAST);
  assign w_full  = (r_count == LP_FULL);
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;
  assign w_rd_nx = r_rd + AW'(1);

  // A packet pushed on the same edge as the pop is
  // not in storage yet, so its header comes from the pins.
  assign w_next_h = (r_count == (AW+1)'(1))
                  ? {in_tmax, in_chnaddr}
                  : r_mem_h[w_rd_nx];

  // Next state and next registered beat.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_first_nxt = r_first;
    w_last_nxt  = r_last;
    w_data_nxt  = r_data;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = S_HEADER;
          w_valid_nxt = 1'b1;
          w_first_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_data_nxt  = f_hdr(r_mem_h[r_rd]);
        end
      end
      S_HEADER: begin
        if (w_xfer) begin
          w_state_nxt = S_BODY;
          w_idx_nxt   = '0;
          w_first_nxt = 1'b0;
          w_last_nxt  = (NBEAT == 1);
          w_data_nxt  = f_beat(r_mem_t[r_rd], '0);
        end
      end
      S_BODY: begin
        if (w_xfer) begin
          if (r_idx == LP_LAST) begin
            w_idx_nxt = '0;
            if ((r_count > (AW+1)'(1)) || w_push) begin
              w_state_nxt = S_HEADER;
              w_valid_nxt = 1'b1;
              w_first_nxt = 1'b1;
              w_last_nxt  = 1'b0;
              w_data_nxt  = f_hdr(w_next_h);
            end else begin
              w_state_nxt = S_IDLE;
              w_valid_nxt = 1'b0;
              w_first_nxt = 1'b0;
              w_last_nxt  = 1'b0;
              w_data_nxt  = '0;
            end
          end else begin
            w_idx_nxt  = r_idx + IW'(1);
            w_last_nxt = (w_idx_nxt == LP_LAST);
            w_data_nxt = f_beat(r_mem_t[r_rd], w_idx_nxt);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_data_nxt  = '0;
      end
    endcase
  end

  // State, beat register, pointers and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
      r_data  <= w_data_nxt;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= w_rd_nx;
      r_count <= r_count + (AW+1)'(w_push)
                         - (AW+1)'(w_pop);
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  // Packet storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_t[r_wr] <= in_tensors;
      r_mem_h[r_wr] <= {in_tmax, in_chnaddr};
    end
  end

  assign m_out.out_valid = r_valid;
  assign m_out.out_first = r_first;
  assign m_out.out_last  = r_last;
  assign m_out.out_data  = r_data;
  assign fifo_count      = r_count;
  assign drop_count      = r_drop;
  assign overflow        = r_ovf;
endmodule

// File: tb/tb_vpu_stream_sink.sv
// tb_vpu_stream_sink: scoreboard bench for the
// tensor stream sink.
module tb_vpu_stream_sink;
  localparam int TW = 1024;
  localparam int BW = 64;
  localparam int AS = 3;
  localparam int NB = TW / BW;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid;
  logic [15:0]   in_chnaddr;
  logic [15:0]   in_tmax;
  logic [TW-1:0] in_tensors;
  logic [AS:0]   fifo_count;
  logic [15:0]   drop_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  int rcnt = 0;
  int nxfer = 0;
  int nvalid = 0;
  int nrise = 0;
  int peak = 0;
  logic prev_v = 1'b0;
  logic stall_v = 1'b0;
  logic [BW-1:0] sd;
  logic sf, sl;
  beat_t exp_q[$];
  beat_t e;

  vpu_stream_sink_if #(.BEAT_WIDTH(BW)) bus ();

  vpu_stream_sink #(
    .TENSOR_WIDTH  (TW),
    .BEAT_WIDTH    (BW),
    .FIFO_ADDR_SIZE(AS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_chnaddr(in_chnaddr),
    .in_tmax   (in_tmax),
    .in_tensors(in_tensors),
    .m_out     (bus),
    .fifo_count(fifo_count),
    .drop_count(drop_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] mk_t(input logic [15:0] s);
    logic [TW-1:0] t;
    for (int i = 0; i < NB; i++)
      t[BW*i +: BW] = {16{4'(i)}} ^ {4{s}};
    return t;
  endfunction

  function automatic logic [BW-1:0] mk_b(
    input logic [15:0] s, input int i
  );
    logic [TW-1:0] t;
    t = mk_t(s);
    return t[BW*i +: BW];
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] c,
                      input logic [15:0] tm,
                      input logic [15:0] s,
                      input bit acc);
    logic [TW-1:0] t;
    t = mk_t(s);
    in_valid   = 1'b1;
    in_chnaddr = c;
    in_tmax    = tm;
    in_tensors = t;
    if (acc) begin
      exp_q.push_back('{data: {32'h0, tm, c},
                        first: 1'b1, last: 1'b0});
      for (int i = 0; i < NB; i++)
        exp_q.push_back('{data: t[BW*i +: BW],
                          first: 1'b0,
                          last: (i == NB-1)});
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_chnaddr = 16'($urandom);
    in_tmax    = 16'($urandom);
    in_tensors = {32{$urandom}};
  endtask

  task automatic drain(input string nm, input int lim);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0)
           && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " queue empty"}, 64'(exp_q.size()), 64'd0);
    chk({nm, " fifo_count"}, 64'(fifo_count), 64'd0);
  endtask

  // Downstream ready pattern: 1 always, 1-0-0 cycle, or 0.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      bus.out_ready = 1'b1;
    else if (rdy_mode == 1) bus.out_ready = (rcnt % 3 == 0);
    else                    bus.out_ready = 1'b0;
    rcnt++;
  end

  // Monitor: pops the scoreboard on each transfer and
  // checks that stalled beats hold.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_v = 1'b0;
      prev_v  = 1'b0;
    end else begin
      if (stall_v) begin
        checks++;
        if (!(bus.out_valid && bus.out_data == sd &&
              bus.out_first == sf && bus.out_last == sl)) begin
          errors++;
          $display("FAIL hold: got v=%b %h f=%b l=%b want v=1 %h f=%b l=%b",
                   bus.out_valid, bus.out_data, bus.out_first,
                   bus.out_last, sd, sf, sl);
        end
      end
      stall_v = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      sf = bus.out_first;
      sl = bus.out_last;
      if (bus.out_valid) nvalid++;
      if (bus.out_valid && !prev_v) nrise++;
      prev_v = bus.out_valid;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (bus.out_valid && bus.out_ready) begin
        nxfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: got unexpected %h f=%b l=%b want none",
                   bus.out_data, bus.out_first, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e.data || bus.out_first !== e.first
              || bus.out_last !== e.last) begin
            errors++;
            $display("FAIL beat: got %h f=%b l=%b want %h f=%b l=%b",
                     bus.out_data, bus.out_first, bus.out_last,
                     e.data, e.first, e.last);
          end
        end
      end
    end
  end

  initial begin
    int n0;
    bit found;
    in_valid      = 1'b0;
    in_chnaddr    = 16'hDEAD;
    in_tmax       = 16'hBEEF;
    in_tensors    = '1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_data", bus.out_data, 64'd0);
    chk("rst first/last", {62'd0, bus.out_first, bus.out_last}, 64'd0);
    chk("rst fifo_count", 64'(fifo_count), 64'd0);
    chk("rst drop/ovf", {47'd0, overflow, drop_count}, 64'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single packet, latency and header layout.
    send(16'h0005, 16'h00A3, 16'h0000, 1'b1);
    chk("t1 count after k", 64'(fifo_count), 64'd1);
    chk("t1 valid after k", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("t1 valid after k+1", 64'(bus.out_valid), 64'd1);
    chk("t1 header", bus.out_data, 64'h0000_0000_00A3_0005);
    chk("t1 first", 64'(bus.out_first), 64'd1);
    drain("t1", 100);

    // Same packet through a 1-0-0 ready pattern.
    rdy_mode = 1;
    n0 = nxfer;
    send(16'h0005, 16'h00A3, 16'h0000, 1'b1);
    drain("t2", 200);
    chk("t2 transfers", 64'(nxfer - n0), 64'd17);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Three back-to-back packets stream without a gap.
    peak   = 0;
    nvalid = 0;
    nrise  = 0;
    send(16'h0001, 16'h0011, 16'h1111, 1'b1);
    send(16'h0002, 16'h0022, 16'h2222, 1'b1);
    send(16'h0003, 16'h0033, 16'h3333, 1'b1);
    drain("t3", 200);
    repeat (2) @(posedge clk);
    #1;
    chk("t3 valid cycles", 64'(nvalid), 64'd51);
    chk("t3 valid bursts", 64'(nrise), 64'd1);
    chk("t3 peak count", 64'(peak), 64'd3);

    // Ten packets into a depth-8 FIFO: two dropped.
    for (int i = 0; i < 10; i++)
      send(16'(16'h10 + i), 16'h0100, 16'(16'h0A00 + i), i < 8);
    chk("t4 fifo_count", 64'(fifo_count), 64'd8);
    chk("t4 drop_count", 64'(drop_count), 64'd2);
    chk("t4 overflow", 64'(overflow), 64'd1);
    drain("t4", 400);

    // Full FIFO: push lands on the last-beat edge.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      send(16'(16'h20 + i), 16'h0200, 16'(16'h0B00 + i), 1'b1);
    chk("t5 full count", 64'(fifo_count), 64'd8);
    rdy_mode = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && bus.out_last) found = 1'b1;
    end
    chk("t5 found last", 64'(found), 64'd1);
    send(16'h0030, 16'h0300, 16'h0C00, 1'b1);
    chk("t5 count held", 64'(fifo_count), 64'd8);
    chk("t5 drop held", 64'(drop_count), 64'd2);
    drain("t5", 400);

    // Reset during body beat 7 with two packets queued.
    send(16'h0041, 16'h0400, 16'h4141, 1'b1);
    send(16'h0042, 16'h0400, 16'h4242, 1'b1);
    send(16'h0043, 16'h0400, 16'h4343, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && !bus.out_first &&
          bus.out_data == mk_b(16'h4141, 7)) found = 1'b1;
    end
    chk("t6 found beat7", 64'(found), 64'd1);
    chk("t6 queued", 64'(fifo_count), 64'd3);
    rstn = 1'b0;
    #1;
    exp_q.delete();
    chk("t6 rst valid", 64'(bus.out_valid), 64'd0);
    chk("t6 rst data", bus.out_data, 64'd0);
    chk("t6 rst first/last", {62'd0, bus.out_first, bus.out_last}, 64'd0);
    chk("t6 rst count", 64'(fifo_count), 64'd0);
    chk("t6 rst drop/ovf", {47'd0, overflow, drop_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t6 idle after rst", 64'(bus.out_valid), 64'd0);
    end
    send(16'h0055, 16'h0500, 16'h5555, 1'b1);
    drain("t6", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
